// File: rtl/ccff_loader_pkg.sv
// Shared types and defaults for the CCFF chain loader.
package ccff_loader_pkg;

  // Default bitstream word width.
  localparam int DEF_WORD_W = 32;

  // Loader control states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } ccff_ld_state_e;

endpackage

// File: rtl/ccff_chain_loader.sv
// Serializes WORD_W-bit bitstream words LSB-first into a CCFF shift chain,
// stopping after exactly CHAIN_LEN shifts. In verify mode the chain tail is
// compared against the re-streamed bitstream and any difference is latched.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int CHAIN_LEN = 70,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              verify,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              mismatch
);

  // word_left must be able to hold a full word.
  localparam int WL_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CHAIN_LEN);

  ccff_ld_state_e    state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WL_W-1:0]   word_left_q, word_left_d;
  logic              vmode_q, vmode_d;
  logic              mismatch_q, mismatch_d;
  logic              head_q, head_d;
  logic              shift_en_q, shift_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  bits_rem;
  logic [CNT_W-1:0]  bit_cnt_inc;

  // Next-state logic for the FSM, serializer, counters and registered outputs.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bit_cnt_d   = bit_cnt_q;
    word_left_d = word_left_q;
    vmode_d     = vmode_q;
    mismatch_d  = mismatch_q;
    bits_rem    = LEN_C - bit_cnt_q;
    bit_cnt_inc = bit_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = WAIT_WORD;
          bit_cnt_d  = '0;
          mismatch_d = 1'b0;
          vmode_d    = verify;
        end
      end
      WAIT_WORD: begin
        // abort wins over the handshake: no word is taken in that cycle
        if (abort) begin
          state_d = IDLE;
        end else if (cfg_valid) begin
          sreg_d = cfg_data;
          // the final word may be only partially used; its upper bits are dropped
          if (int'(bits_rem) < WORD_W) begin
            word_left_d = WL_W'(bits_rem);
          end else begin
            word_left_d = WL_W'(WORD_W);
          end
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          sreg_d      = sreg_q >> 1;
          bit_cnt_d   = bit_cnt_inc;
          word_left_d = word_left_q - 1'b1;
          // tail holds the bit shifted CHAIN_LEN shifts ago; compare before this edge
          if (vmode_q && (ccff_tail != sreg_q[0])) begin
            mismatch_d = 1'b1;
          end
          if (bit_cnt_inc == LEN_C) begin
            state_d = DONE;
          end else if (word_left_q == WL_W'(1)) begin
            state_d = WAIT_WORD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with the FSM.
    shift_en_d = (state_d == SHIFT);
    head_d     = (state_d == SHIFT) ? sreg_d[0] : 1'b0;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      bit_cnt_q   <= '0;
      word_left_q <= '0;
      vmode_q     <= 1'b0;
      mismatch_q  <= 1'b0;
      head_q      <= 1'b0;
      shift_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bit_cnt_q   <= bit_cnt_d;
      word_left_q <= word_left_d;
      vmode_q     <= vmode_d;
      mismatch_q  <= mismatch_d;
      head_q      <= head_d;
      shift_en_q  <= shift_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // cfg_ready is a direct decode of the state register.
  assign cfg_ready     = (state_q == WAIT_WORD);
  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign mismatch      = mismatch_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: 70-bit and 32-bit chain models.
module tb_ccff_chain_loader;

    logic prog_clk = 1'b0;
    logic prog_rst_n = 1'b0;

    // 70-bit chain instance
    logic        start_a = 0, verify_a = 0, abort_a = 0, cfg_valid_a = 0;
    logic [31:0] cfg_data_a = '0;
    logic        cfg_ready_a, head_a, shift_en_a, tail_a, busy_a, done_a, mismatch_a;

    // 32-bit chain instance
    logic        start_b = 0, verify_b = 0, abort_b = 0, cfg_valid_b = 0;
    logic [31:0] cfg_data_b = '0;
    logic        cfg_ready_b, head_b, shift_en_b, tail_b, busy_b, done_b, mismatch_b;

    int total = 0;
    int bad = 0;

    logic [69:0] chain_a = '0;
    logic [31:0] chain_b = '0;
    logic        flip_req = 1'b0;
    int          shift_tot_a = 0, done_tot_a = 0;
    int          shift_tot_b = 0, done_tot_b = 0;
    logic        hlog [0:1023];

    logic [31:0] words [3] = '{32'hA5A5A5A5, 32'h12345678, 32'h0000003F};
    logic [69:0] s_exp = {6'h3F, 32'h12345678, 32'hA5A5A5A5};

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.WORD_W(32), .CHAIN_LEN(70)) dut_a (
        .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start_a), .verify(verify_a),
        .abort(abort_a), .cfg_data(cfg_data_a), .cfg_valid(cfg_valid_a), .cfg_ready(cfg_ready_a),
        .ccff_head(head_a), .ccff_shift_en(shift_en_a), .ccff_tail(tail_a), .busy(busy_a),
        .done(done_a), .mismatch(mismatch_a)
    );

    ccff_chain_loader #(.WORD_W(32), .CHAIN_LEN(32)) dut_b (
        .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start_b), .verify(verify_b),
        .abort(abort_b), .cfg_data(cfg_data_b), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
        .ccff_head(head_b), .ccff_shift_en(shift_en_b), .ccff_tail(tail_b), .busy(busy_b),
        .done(done_b), .mismatch(mismatch_b)
    );

    assign tail_a = chain_a[69];
    assign tail_b = chain_b[31];

    // Chain models plus shift/done/head monitors.
    always @(posedge prog_clk) begin
        if (flip_req) chain_a[40] <= ~chain_a[40];
        else if (shift_en_a) chain_a <= {chain_a[68:0], head_a};
        if (shift_en_a) begin
            hlog[shift_tot_a % 1024] <= head_a;
            shift_tot_a <= shift_tot_a + 1;
        end
        if (done_a) done_tot_a <= done_tot_a + 1;
        if (shift_en_b) begin
            chain_b <= {chain_b[30:0], head_b};
            shift_tot_b <= shift_tot_b + 1;
        end
        if (done_b) done_tot_b <= done_tot_b + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [69:0] rev70(input logic [69:0] x);
        logic [69:0] r;
        for (int k = 0; k < 70; k++) r[k] = x[69-k];
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = x[31-k];
        return r;
    endfunction

    task automatic fail(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge prog_clk);
        #1;
    endtask

    // Runs one complete 3-word operation on the 70-bit instance; returns in the done cycle.
    task automatic load_a(input logic v, input int maxgap, input logic poke_start);
        int n;
        int g;
        start_a = 1'b1; verify_a = v;
        cycle();
        start_a = 1'b0; verify_a = 1'b0;
        total++; if (busy_a !== 1'b1) fail("start_busy", busy_a, 1'b1);
        total++; if (mismatch_a !== 1'b0) fail("start_clears_mismatch", mismatch_a, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (cfg_ready_a !== 1'b1 && n < 100) begin cycle(); n++; end
            total++; if (cfg_ready_a !== 1'b1) fail("ready_wait", cfg_ready_a, 1'b1);
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            if (poke_start && i == 1 && g == 0) g = 1;
            for (int j = 0; j < g; j++) begin
                total++; if (shift_en_a !== 1'b0) fail("gap_shift_en", shift_en_a, 1'b0);
                if (poke_start && i == 1 && j == 0) start_a = 1'b1;
                cycle();
                start_a = 1'b0;
            end
            cfg_data_a = words[i]; cfg_valid_a = 1'b1;
            cycle();
            cfg_valid_a = 1'b0; cfg_data_a = $urandom;
            total++; if (shift_en_a !== 1'b1) fail("shift_after_accept", shift_en_a, 1'b1);
        end
        n = 0;
        while (done_a !== 1'b1 && n < 200) begin cycle(); n++; end
        total++; if (done_a !== 1'b1) fail("done_wait", done_a, 1'b1);
    endtask

    // Post-completion checks against the reference 70-bit bitstream.
    task automatic finish_checks(input int base_s, input int base_d);
        logic [69:0] hs;
        total++; if (busy_a !== 1'b1) fail("busy_at_done", busy_a, 1'b1);
        cycle();
        total++; if (busy_a !== 1'b0) fail("busy_after_done", busy_a, 1'b0);
        total++; if (done_a !== 1'b0) fail("done_one_cycle", done_a, 1'b0);
        total++; if (shift_tot_a - base_s !== 70) fail("shift_count", shift_tot_a - base_s, 70);
        total++; if (done_tot_a - base_d !== 1) fail("done_count", done_tot_a - base_d, 1);
        for (int k = 0; k < 70; k++) hs[k] = hlog[(base_s + k) % 1024];
        total++; if (hs !== s_exp) fail("head_sequence", hs, s_exp);
        total++; if (chain_a !== rev70(s_exp)) fail("chain_contents", chain_a, rev70(s_exp));
    endtask

    initial begin
        int bs;
        int bd;
        int n;

        // reset values
        repeat (2) cycle();
        total++;
        if ({cfg_ready_a, head_a, shift_en_a, busy_a, done_a, mismatch_a} !== 6'b0)
            fail("reset_outs_a", {cfg_ready_a, head_a, shift_en_a, busy_a, done_a, mismatch_a}, 6'b0);
        total++;
        if ({cfg_ready_b, head_b, shift_en_b, busy_b, done_b, mismatch_b} !== 6'b0)
            fail("reset_outs_b", {cfg_ready_b, head_b, shift_en_b, busy_b, done_b, mismatch_b}, 6'b0);
        prog_rst_n = 1'b1;
        cycle();

        // basic load
        bs = shift_tot_a; bd = done_tot_a;
        load_a(1'b0, 0, 1'b0);
        finish_checks(bs, bd);

        // verify, clean chain
        load_a(1'b1, 0, 1'b0);
        total++; if (mismatch_a !== 1'b0) fail("verify_clean_mismatch", mismatch_a, 1'b0);
        cycle();

        // verify, chain bit 40 corrupted
        flip_req = 1'b1;
        cycle();
        flip_req = 1'b0;
        load_a(1'b1, 0, 1'b0);
        total++; if (mismatch_a !== 1'b1) fail("verify_corrupt_mismatch", mismatch_a, 1'b1);
        repeat (3) cycle();
        total++; if (mismatch_a !== 1'b1) fail("mismatch_sticky", mismatch_a, 1'b1);
        total++; if (busy_a !== 1'b0) fail("idle_after_verify", busy_a, 1'b0);

        // backpressure with a start pulse while busy; start also clears mismatch
        bs = shift_tot_a; bd = done_tot_a;
        load_a(1'b0, 5, 1'b1);
        finish_checks(bs, bd);

        // abort in the 10th shift cycle of word 2
        bs = shift_tot_a; bd = done_tot_a;
        start_a = 1'b1;
        cycle();
        start_a = 1'b0;
        cfg_data_a = words[0]; cfg_valid_a = 1'b1;
        cycle();
        cfg_valid_a = 1'b0;
        n = 0;
        while (cfg_ready_a !== 1'b1 && n < 100) begin cycle(); n++; end
        total++; if (cfg_ready_a !== 1'b1) fail("abort_ready_wait", cfg_ready_a, 1'b1);
        cfg_data_a = words[1]; cfg_valid_a = 1'b1;
        cycle();
        cfg_valid_a = 1'b0;
        repeat (9) cycle();
        total++; if (shift_en_a !== 1'b1) fail("abort_in_shift", shift_en_a, 1'b1);
        abort_a = 1'b1;
        cycle();
        abort_a = 1'b0;
        cycle();
        total++; if (busy_a !== 1'b0) fail("abort_busy_low", busy_a, 1'b0);
        total++; if (cfg_ready_a !== 1'b0) fail("abort_ready_low", cfg_ready_a, 1'b0);
        repeat (4) cycle();
        total++; if (done_tot_a - bd !== 0) fail("abort_no_done", done_tot_a - bd, 0);
        total++; if (shift_tot_a - bs !== 42) fail("abort_shift_count", shift_tot_a - bs, 42);
        bs = shift_tot_a; bd = done_tot_a;
        load_a(1'b0, 0, 1'b0);
        finish_checks(bs, bd);

        // asynchronous reset mid-SHIFT
        start_a = 1'b1;
        cycle();
        start_a = 1'b0;
        cfg_data_a = 32'hFFFFFFFF; cfg_valid_a = 1'b1;
        cycle();
        cfg_valid_a = 1'b0;
        repeat (3) cycle();
        total++;
        if ({shift_en_a, head_a, busy_a} !== 3'b111)
            fail("pre_reset_active", {shift_en_a, head_a, busy_a}, 3'b111);
        #2 prog_rst_n = 1'b0;
        #1;
        total++;
        if ({cfg_ready_a, head_a, shift_en_a, busy_a, done_a, mismatch_a} !== 6'b0)
            fail("async_reset_outs", {cfg_ready_a, head_a, shift_en_a, busy_a, done_a, mismatch_a}, 6'b0);
        cycle();
        prog_rst_n = 1'b1;
        cycle();
        total++; if (busy_a !== 1'b0) fail("idle_after_reset", busy_a, 1'b0);

        // CHAIN_LEN = 32: a single word completes
        bs = shift_tot_b; bd = done_tot_b;
        start_b = 1'b1;
        cycle();
        start_b = 1'b0;
        total++; if (cfg_ready_b !== 1'b1) fail("b_ready", cfg_ready_b, 1'b1);
        cfg_data_b = 32'hDEADBEEF; cfg_valid_b = 1'b1;
        cycle();
        cfg_valid_b = 1'b0;
        n = 0;
        while (done_b !== 1'b1 && n < 100) begin cycle(); n++; end
        total++; if (done_b !== 1'b1) fail("b_done_wait", done_b, 1'b1);
        total++; if (shift_tot_b - bs !== 32) fail("b_shift_count", shift_tot_b - bs, 32);
        total++; if (chain_b !== rev32(32'hDEADBEEF)) fail("b_chain", chain_b, rev32(32'hDEADBEEF));
        cycle();
        total++; if (busy_b !== 1'b0) fail("b_busy_low", busy_b, 1'b0);
        total++; if (done_tot_b - bd !== 1) fail("b_done_count", done_tot_b - bd, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
